// File: rtl/match_window_counter.sv
// Counts detector pulses over fixed WINDOW-cycle windows and offers each window count on a valid/ready port.
// Optional threshold alarm enabled by defining MATCH_ALARM_EN.
//
// state | meaning
// IDLE  | not counting; wcyc and acc held at 0
// COUNT | counting pulses inside a window; wcyc is the window cycle index
module match_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             z_in,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             ovf,
  output logic             dropped,
  output logic             alarm
);

  localparam int WW = $clog2(WINDOW);
  localparam logic [WW-1:0]    WCYC_LAST = WW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ACC_MAX   = '1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_nxt;
  logic [WW-1:0]    wcyc, wcyc_nxt;
  logic [CNT_W-1:0] acc, acc_nxt, cnt_fin;
  logic             sat, sat_nxt, sat_fin;
  logic             active, win_end, load, accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcyc  <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      wcyc  <= wcyc_nxt;
      acc   <= acc_nxt;
      sat   <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcyc_nxt  = '0;
    acc_nxt   = '0;
    sat_nxt   = 1'b0;
    active    = 1'b0;
    win_end   = 1'b0;
    cnt_fin   = acc;
    sat_fin   = sat;

    // Count including this cycle's pulse; hold at max and flag the lost increment.
    if (z_in) begin
      if (acc == ACC_MAX) sat_fin = 1'b1;
      else                cnt_fin = acc + 1'b1;
    end

    case (state)
      IDLE: begin
        if (en) begin
          active    = 1'b1;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        win_end = (wcyc == WCYC_LAST);
        // A window that ends as en drops still completes.
        active  = en || win_end;
        if (!en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (active && !win_end) begin
      wcyc_nxt = wcyc + 1'b1;
      acc_nxt  = cnt_fin;
      sat_nxt  = sat_fin;
    end
  end

  assign accept = cnt_valid && cnt_ready;
  assign load   = win_end && (!cnt_valid || cnt_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      ovf       <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      dropped <= win_end && cnt_valid && !cnt_ready;
      if (load) begin
        cnt_out   <= cnt_fin;
        ovf       <= sat_fin;
        cnt_valid <= 1'b1;
      end else if (accept) begin
        cnt_out   <= '0;
        ovf       <= 1'b0;
        cnt_valid <= 1'b0;
      end
    end
  end

`ifdef MATCH_ALARM_EN
  localparam logic [31:0] THRESH_V = 32'(THRESH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm <= 1'b0;
    end else if (load) begin
      alarm <= (32'(cnt_fin) >= THRESH_V);
    end else if (accept) begin
      alarm <= 1'b0;
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: doc/match_window_counter.md
# match_window_counter

Downstream stage of the serial sequence detector. Consumes the one-cycle detection pulse `z` and counts matches over fixed windows of `WINDOW` clock cycles. Each completed window's count is presented on a valid/ready output port. Flags mark saturation and lost results, and an optional threshold alarm is available.

## Interface
- `WINDOW`, 16: window length in clock cycles; legal range is 2 or more.
- `CNT_W`, 8: width of the count; the count saturates at 2^CNT_W-1.
- `THRESH`, 4: alarm threshold. Used only when `MATCH_ALARM_EN` is defined.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  counting enable.
- `z_in`  in  1  detection pulse from the detector, sampled every cycle. Back-to-back pulses are legal.
- `cnt_out`  out  CNT_W  count of the completed window.
- `cnt_valid`  out  1  `cnt_out`, `ovf` and `alarm` are valid.
- `cnt_ready`  in  1  consumer accepts the result when `cnt_valid && cnt_ready`.
- `ovf`  out  1  the window in `cnt_out` saturated.
- `dropped`  out  1  one-cycle pulse: a completed window result was discarded.
- `alarm`  out  1  the window in `cnt_out` reached `THRESH`.

## Operation
- **FSM states:** IDLE and COUNT.
  - IDLE -> COUNT when `en`=1. The `z_in` of that same cycle counts as window cycle 0.
  - COUNT -> IDLE when `en`=0.
- **Window abort:** on COUNT -> IDLE, `wcyc` and `acc` clear and the partial window is discarded. A pending output result is untouched and still deliverable.
- **Counting:**
  - `wcyc` counts 0..WINDOW-1.
  - `acc` increments on each cycle with `z_in`=1 and holds at 2^CNT_W-1; it never wraps.
  - The saturation flag sets when an increment is attempted at the maximum value.
- **Window end** (cycle with `wcyc`=WINDOW-1 in COUNT):
  - The final count includes that cycle's `z_in`.
  - The count and saturation flag are offered to the output register.
  - `wcyc` and `acc` restart at 0 on the next cycle with no gap cycle.
- **Output register:**
  - Loads when it is empty or being accepted in the same cycle; `cnt_valid` then stays or becomes 1.
  - If `cnt_valid`=1 and `cnt_ready`=0 at window end, the new result is discarded, the old result is held, and `dropped` pulses on the next cycle.
  - `cnt_valid` clears on acceptance unless a new load happens in the same cycle.
- **Stability:** `cnt_out`, `ovf` and `alarm` are stable while `cnt_valid`=1 and not yet accepted.
- **Reset (async, `rst`=0):**
  - FSM goes to IDLE; `wcyc`, `acc` and the output register clear.
  - All outputs are 0 immediately, including mid-window and with a pending result. Nothing is retained.

## Timing
- `cnt_valid` rises on the cycle after window end. From the first cycle with `en`=1, the first result appears at cycle WINDOW.
- Throughput: one result per WINDOW cycles. With `cnt_ready` held at 1, no result is ever dropped.
- `dropped` is a single-cycle, registered pulse.
- All outputs are registered; there is no combinational path from `cnt_ready` to `cnt_valid`.
- `en` deasserted on the window-end cycle: the window still completes and its result is offered; the FSM then returns to IDLE.

## Configuration
- `MATCH_ALARM_EN` defined:
  - `alarm` is registered with the result and set when the window count is THRESH or more.
  - It is held with `cnt_out` and clears with the result on acceptance.
- `MATCH_ALARM_EN` undefined:
  - The alarm logic is absent and `alarm` is tied to 0.
  - `THRESH` is ignored.

## Test plan
All scenarios use `WINDOW`=16, `CNT_W`=8, `THRESH`=4 unless stated otherwise.
1. **Reset:** hold `rst`=0 for 3 cycles, then also pulse it mid-window with a pending result -> all outputs 0 immediately; the next window counts from 0.
2. **Basic count:** `en`=1 at cycle 0; `z_in` pulses at window cycles 2, 5, 8; `cnt_ready`=1 -> at cycle 16, `cnt_valid`=1 for one cycle with `cnt_out`=3, `ovf`=0.
3. **Backpressure:** `cnt_ready`=0; window A has 2 pulses and window B has 5 -> `cnt_out` stays 2 and `dropped` pulses once at cycle 32. Raising `cnt_ready` accepts 2; window C then delivers its own count.
4. **Saturation:** `CNT_W`=3; `z_in`=1 for all 16 cycles -> `cnt_out`=7, `ovf`=1. The next window with 1 pulse gives `cnt_out`=1, `ovf`=0.
5. **Abort:** drop `en` at window cycle 9 after 2 pulses -> no result. Re-enable with 1 pulse in the fresh window -> `cnt_out`=1, arriving 16 cycles after re-enable.
6. **Alarm:**
   - Window with 4 pulses -> `alarm`=1 when the macro is defined, 0 when it is undefined.
   - Window with 3 pulses -> `alarm`=0.
   - Simultaneous accept and load keeps `cnt_valid`=1 with the new values.
